// File: rtl/multi_port_reg_file.sv
// rtl/multi_port_reg_file.sv - two-write/two-read register file with byte masks and write-first bypass
module multi_port_reg_file #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    writeEnable0,
    input  logic                    writeEnable1,
    input  logic [ADDR_WIDTH-1:0]   writeRegister0,
    input  logic [ADDR_WIDTH-1:0]   writeRegister1,
    input  logic [WIDTH-1:0]        writeData0,
    input  logic [WIDTH-1:0]        writeData1,
    input  logic [WIDTH/8-1:0]      writeMask0,
    input  logic [WIDTH/8-1:0]      writeMask1,
    input  logic                    readEnable1,
    input  logic                    readEnable2,
    input  logic [ADDR_WIDTH-1:0]   readRegister1,
    input  logic [ADDR_WIDTH-1:0]   readRegister2,
    output logic [WIDTH-1:0]        readData1,
    output logic [WIDTH-1:0]        readData2,
    output logic                    readValid1,
    output logic                    readValid2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = WIDTH / 8;

    logic [WIDTH-1:0] regs      [DEPTH];
    logic [WIDTH-1:0] next_regs [DEPTH];

    // Post-write view of every entry; port 1 is applied last so it wins per byte,
    // and reads take from this view to get write-first behaviour.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            next_regs[i] = regs[i];
            for (int b = 0; b < NB; b++) begin
                if (writeEnable0 && writeRegister0 == ADDR_WIDTH'(i) && writeMask0[b])
                    next_regs[i][8*b +: 8] = writeData0[8*b +: 8];
                if (writeEnable1 && writeRegister1 == ADDR_WIDTH'(i) && writeMask1[b])
                    next_regs[i][8*b +: 8] = writeData1[8*b +: 8];
            end
            if (ZERO_REG != 0 && i == 0)
                next_regs[i] = '0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            readData1  <= '0;
            readData2  <= '0;
            readValid1 <= 1'b0;
            readValid2 <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= next_regs[i];
            if (readEnable1)
                readData1 <= next_regs[readRegister1];
            if (readEnable2)
                readData2 <= next_regs[readRegister2];
            readValid1 <= readEnable1;
            readValid2 <= readEnable2;
        end
    end
endmodule

// File: tb/tb_multi_port_reg_file.sv
// tb/tb_multi_port_reg_file.sv - scoreboard bench for multi_port_reg_file
module tb_multi_port_reg_file;
    logic        clock = 1'b0;
    logic        resetN;
    logic        writeEnable0, writeEnable1;
    logic [4:0]  writeRegister0, writeRegister1;
    logic [31:0] writeData0, writeData1;
    logic [3:0]  writeMask0, writeMask1;
    logic        readEnable1, readEnable2;
    logic [4:0]  readRegister1, readRegister2;
    logic [31:0] readData1, readData2;
    logic        readValid1, readValid2;

    typedef struct {
        logic [31:0] d1;
        logic        v1;
        logic [31:0] d2;
        logic        v2;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] model [32];
    logic [31:0] exp_d1, exp_d2;
    int          checks = 0;
    int          failures = 0;

    multi_port_reg_file #(.WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clock(clock), .resetN(resetN),
        .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
        .writeRegister0(writeRegister0), .writeRegister1(writeRegister1),
        .writeData0(writeData0), .writeData1(writeData1),
        .writeMask0(writeMask0), .writeMask1(writeMask1),
        .readEnable1(readEnable1), .readEnable2(readEnable2),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .readData1(readData1), .readData2(readData2),
        .readValid1(readValid1), .readValid2(readValid2)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        exp_d1 = 32'h0;
        exp_d2 = 32'h0;
    endtask

    // Drive one cycle of stimulus, push the expected read outputs, advance past the edge.
    task automatic step(input logic we0, input logic [4:0] wr0, input logic [31:0] wd0, input logic [3:0] wm0,
                        input logic we1, input logic [4:0] wr1, input logic [31:0] wd1, input logic [3:0] wm1,
                        input logic re1, input logic [4:0] rr1, input logic re2, input logic [4:0] rr2);
        exp_t        x;
        logic [31:0] nm [32];
        @(negedge clock);
        writeEnable0 = we0; writeRegister0 = wr0; writeData0 = wd0; writeMask0 = wm0;
        writeEnable1 = we1; writeRegister1 = wr1; writeData1 = wd1; writeMask1 = wm1;
        readEnable1 = re1; readRegister1 = rr1; readEnable2 = re2; readRegister2 = rr2;
        nm = model;
        for (int b = 0; b < 4; b++) begin
            if (we0 && wm0[b]) nm[wr0][8*b +: 8] = wd0[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (we1 && wm1[b]) nm[wr1][8*b +: 8] = wd1[8*b +: 8];
        end
        nm[0] = 32'h0;
        if (re1) exp_d1 = nm[rr1];
        if (re2) exp_d2 = nm[rr2];
        x.d1 = exp_d1; x.v1 = re1; x.d2 = exp_d2; x.v2 = re2;
        q.push_back(x);
        model = nm;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        @(negedge clock);
        writeEnable0 = 0; writeEnable1 = 0; readEnable1 = 0; readEnable2 = 0;
        writeRegister0 = 0; writeRegister1 = 0; writeData0 = 0; writeData1 = 0;
        writeMask0 = 0; writeMask1 = 0; readRegister1 = 0; readRegister2 = 0;
    endtask

    task automatic test_reset();
        idle();
        resetN = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", readData1); end
        checks++; if (readData2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 got=%h exp=0", readData2); end
        checks++; if (readValid1 !== 1'b0) begin failures++; $display("FAIL reset_rv1 got=%b exp=0", readValid1); end
        checks++; if (readValid2 !== 1'b0) begin failures++; $display("FAIL reset_rv2 got=%b exp=0", readValid2); end
        @(negedge clock);
        resetN = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd1, 1, 5'd31);
        e = q.pop_front();
        checks++; if (readData1 !== e.d1 || readValid1 !== e.v1) begin failures++; $display("FAIL reset_read_r1 got=%h/%b exp=%h/%b", readData1, readValid1, e.d1, e.v1); end
        checks++; if (readData2 !== e.d2 || readValid2 !== e.v2) begin failures++; $display("FAIL reset_read_r31 got=%h/%b exp=%h/%b", readData2, readValid2, e.d2, e.v2); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd31, 1, 5'd1);
        e = q.pop_front();
        checks++; if (readData1 !== 32'h0 || readValid1 !== 1'b1) begin failures++; $display("FAIL reset_read_swap1 got=%h/%b exp=0/1", readData1, readValid1); end
        checks++; if (readData2 !== 32'h0 || readValid2 !== 1'b1) begin failures++; $display("FAIL reset_read_swap2 got=%h/%b exp=0/1", readData2, readValid2); end
    endtask

    task automatic test_write_read();
        step(1, 5'd20, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        e = q.pop_front();
        checks++; if (readValid1 !== 1'b0) begin failures++; $display("FAIL wr_no_valid got=%b exp=0", readValid1); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd20, 0, 0);
        e = q.pop_front();
        checks++; if (readData1 !== 32'hAAAAAAAA || readValid1 !== 1'b1) begin failures++; $display("FAIL wr_read20 got=%h/%b exp=aaaaaaaa/1", readData1, readValid1); end
        step(1, 5'd20, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 0, 1, 5'd20);
        e = q.pop_front();
        checks++; if (readData2 !== e.d2 || readData2 !== 32'hAAAAAAAA) begin failures++; $display("FAIL mask_zero got=%h exp=aaaaaaaa", readData2); end
    endtask

    task automatic test_bypass();
        step(1, 5'd21, 32'h55555555, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        e = q.pop_front();
        step(0, 0, 0, 0, 1, 5'd21, 32'h12345678, 4'h3, 1, 5'd21, 0, 0);
        e = q.pop_front();
        checks++; if (readData1 !== 32'h55555678 || readData1 !== e.d1) begin failures++; $display("FAIL bypass got=%h exp=55555678", readData1); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd21);
        e = q.pop_front();
        checks++; if (readData2 !== 32'h55555678) begin failures++; $display("FAIL bypass_stored got=%h exp=55555678", readData2); end
    endtask

    task automatic test_collision();
        step(1, 5'd9, 32'h11111111, 4'hF, 1, 5'd9, 32'h22222222, 4'h5, 0, 0, 0, 0);
        e = q.pop_front();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 1, 5'd9);
        e = q.pop_front();
        checks++; if (readData1 !== 32'h11221122) begin failures++; $display("FAIL collision_p1 got=%h exp=11221122", readData1); end
        checks++; if (readData2 !== readData1 || readValid2 !== 1'b1) begin failures++; $display("FAIL collision_same got=%h exp=%h", readData2, e.d2); end
    endtask

    task automatic test_zero_reg();
        step(1, 5'd0, 32'hFFFFFFFF, 4'hF, 1, 5'd0, 32'hFFFFFFFF, 4'hF, 1, 5'd0, 0, 0);
        e = q.pop_front();
        checks++; if (readData1 !== 32'h0) begin failures++; $display("FAIL zero_bypass got=%h exp=0", readData1); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd20, 1, 5'd0);
        e = q.pop_front();
        checks++; if (readData2 !== 32'h0) begin failures++; $display("FAIL zero_read got=%h exp=0", readData2); end
        step(1, 5'd20, 32'h01020304, 4'hF, 0, 0, 0, 0, 0, 5'd20, 0, 0);
        e = q.pop_front();
        checks++; if (readData1 !== 32'hAAAAAAAA || readValid1 !== 1'b0) begin failures++; $display("FAIL hold got=%h/%b exp=aaaaaaaa/0", readData1, readValid1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            step(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 4'($urandom),
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom, 4'($urandom),
                 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
            e = q.pop_front();
            checks++;
            if (readData1 !== e.d1 || readValid1 !== e.v1 || readData2 !== e.d2 || readValid2 !== e.v2) begin
                failures++;
                $display("FAIL random[%0d] got=%h/%b %h/%b exp=%h/%b %h/%b", n, readData1, readValid1,
                         readData2, readValid2, e.d1, e.v1, e.d2, e.v2);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 5'd5, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        e = q.pop_front();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 5'd5);
        e = q.pop_front();
        checks++; if (readData1 !== 32'hDEADBEEF || readData2 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset got=%h %h exp=deadbeef", readData1, readData2); end
        @(negedge clock);
        writeEnable0 = 1; writeRegister0 = 5'd5; writeData0 = 32'h12345678; writeMask0 = 4'hF;
        #2 resetN = 0;
        #1;
        checks++; if (readData1 !== 32'h0 || readData2 !== 32'h0 || readValid1 !== 1'b0 || readValid2 !== 1'b0) begin
            failures++; $display("FAIL async_clear got=%h/%b %h/%b exp=0", readData1, readValid1, readData2, readValid2);
        end
        model_clear();
        @(posedge clock);
        #1;
        checks++; if (readData1 !== 32'h0 || readValid1 !== 1'b0) begin failures++; $display("FAIL reset_ignores got=%h/%b exp=0/0", readData1, readValid1); end
        idle();
        resetN = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
        e = q.pop_front();
        checks++; if (readData1 !== 32'h0 || readValid1 !== 1'b1) begin failures++; $display("FAIL post_reset_r5 got=%h/%b exp=0/1", readData1, readValid1); end
    endtask

    initial begin
        resetN = 1;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_port_reg_file.md
MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; depth SHALL be 2**ADDR_WIDTH.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 SHALL be hardwired to zero.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 resetN  input  1  reset, asynchronous, active-low.
REQ-006 writeEnable0, writeEnable1  input  1 each  write request, ports 0 and 1.
REQ-007 writeRegister0, writeRegister1  input  ADDR_WIDTH each  write address.
REQ-008 writeData0, writeData1  input  WIDTH each  write data.
REQ-009 writeMask0, writeMask1  input  WIDTH/8 each  byte enables; bit i covers bits [8i+7:8i].
REQ-010 readEnable1, readEnable2  input  1 each  read request, ports 1 and 2.
REQ-011 readRegister1, readRegister2  input  ADDR_WIDTH each  read address.
REQ-012 readData1, readData2  output  WIDTH each  registered read data.
REQ-013 readValid1, readValid2  output  1 each  high for one cycle when the matching readData was updated at the last edge.

Function
REQ-014 Write: at a rising edge with writeEnableN=1, each byte of entry writeRegisterN with writeMaskN bit set SHALL take the matching writeDataN byte; unmasked bytes SHALL hold.
REQ-015 Mask all-zero with writeEnable=1 SHALL leave the entry unchanged.
REQ-016 Dual-write collision (same address, both enabled): per byte, port 1 SHALL win where writeMask1 is set; bytes set only in writeMask0 SHALL take port 0 data.
REQ-017 ZERO_REG=1: writes to address 0 SHALL be discarded; reads of address 0 SHALL return 0.
REQ-018 Read latency: one cycle; at an edge with readEnableN=1, readDataN SHALL load the entry at readRegisterN and readValidN SHALL be 1 the following cycle.
REQ-019 Write-first bypass: a read of an address written at the same edge SHALL return the post-write value, merged per byte under the masks and REQ-016.
REQ-020 At an edge with readEnableN=0, readDataN SHALL hold its previous value and readValidN SHALL be 0.
REQ-021 Both read ports SHALL be independent; both reading the same address SHALL return identical data.
REQ-022 No output SHALL ever be X or Z after reset release.

Reset
REQ-023 resetN=0 SHALL immediately, without waiting for clock, clear every entry, readData1, readData2, readValid1 and readValid2 to 0.
REQ-024 While resetN=0, write and read requests SHALL be ignored.
REQ-025 Reset asserted mid-operation SHALL discard any write or read of that cycle; the first edge with resetN=1 SHALL operate normally.

Verification
REQ-026 Reset, then read registers 1 and 31 on both ports -> readData=0, readValid=1 one cycle later.
REQ-027 Write reg 20=0xAAAAAAAA (mask 0xF) via port 0; next cycle read port 1 reg 20 -> 0xAAAAAAAA, readValid1=1.
REQ-028 Reg 21=0x55555555; write port 1 reg 21 data 0x12345678 mask 0x3 while reading reg 21 same edge -> readData=0x55555678.
REQ-029 Same edge: port 0 writes reg 9=0x11111111 mask 0xF, port 1 writes reg 9=0x22222222 mask 0x5 -> reg 9 reads 0x11221122.
REQ-030 ZERO_REG=1: write reg 0=0xFFFFFFFF -> read reg 0 = 0; readEnable low -> readData holds, readValid=0.
REQ-031 Reg 5=0xDEADBEEF; assert resetN=0 between edges -> readData and readValid 0 immediately; reg 5 reads 0 after release.
